// File: rtl/isa_cycle_master.sv
// ISA bus initiator: single-beat host requests become ISA I/O or memory cycles with wait states.
// Define ISA_RDY_SYNC_EN to pass bus_rdy through a two-flop synchronizer before use.
module isa_cycle_master #(
    parameter int unsigned SETUP_CYCLES = 1,
    parameter int unsigned CMD_CYCLES   = 4,
    parameter int unsigned HOLD_CYCLES  = 1,
    parameter int unsigned RDY_TIMEOUT  = 255
) (
    input  logic        clk,
    input  logic        reset_l,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [1:0]  req_type,
    input  logic [19:0] req_addr,
    input  logic [7:0]  req_wdata,
    output logic        rsp_valid,
    output logic [7:0]  rsp_rdata,
    output logic        rsp_timeout,
    output logic [19:0] bus_a,
    output logic        bus_aen,
    output logic        bus_ior_l,
    output logic        bus_iow_l,
    output logic        bus_memr_l,
    output logic        bus_memw_l,
    output logic [7:0]  bus_d_out,
    output logic        bus_d_oe,
    input  logic [7:0]  bus_d_in,
    input  logic        bus_rdy
);

    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(SETUP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(CMD_CYCLES - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] WAIT_LIMIT = CNT_W'(RDY_TIMEOUT);

    localparam logic [1:0] T_IOR  = 2'b00;
    localparam logic [1:0] T_IOW  = 2'b01;
    localparam logic [1:0] T_MEMR = 2'b10;
    localparam logic [1:0] T_MEMW = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETUP,
        ST_CMD,
        ST_HOLD
    } state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] wait_q, wait_d;
    logic [1:0]       type_q, type_d;
    logic             rdy_c;

    logic        req_ready_d, rsp_valid_d, rsp_timeout_d, bus_aen_d, bus_d_oe_d;
    logic        bus_ior_l_d, bus_iow_l_d, bus_memr_l_d, bus_memw_l_d;
    logic [7:0]  rsp_rdata_d, bus_d_out_d;
    logic [19:0] bus_a_d;

`ifdef ISA_RDY_SYNC_EN
    logic [1:0] rdy_sync_q;

    // bus_rdy comes from another domain; two flops before the FSM looks at it
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) rdy_sync_q <= 2'b11;
        else          rdy_sync_q <= {rdy_sync_q[0], bus_rdy};
    end
    assign rdy_c = rdy_sync_q[1];
`else
    assign rdy_c = bus_rdy;
`endif

    // Next state, counters and the next value of every registered output
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        wait_d        = wait_q;
        type_d        = type_q;
        bus_a_d       = bus_a;
        bus_d_out_d   = bus_d_out;
        rsp_rdata_d   = rsp_rdata;
        rsp_timeout_d = rsp_timeout;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    state_d       = ST_SETUP;
                    cnt_d         = '0;
                    wait_d        = '0;
                    type_d        = req_type;
                    bus_a_d       = req_type[1] ? req_addr : {4'h0, req_addr[15:0]};
                    bus_d_out_d   = req_wdata;
                    rsp_rdata_d   = 8'hFF;
                    rsp_timeout_d = 1'b0;
                end
            end
            ST_SETUP: begin
                if (cnt_q == SETUP_LAST) begin
                    state_d = ST_CMD;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_CMD: begin
                if (cnt_q < CMD_LAST) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end else if (rdy_c) begin
                    state_d     = ST_HOLD;
                    cnt_d       = '0;
                    rsp_rdata_d = type_q[0] ? 8'hFF : bus_d_in;
                end else if (wait_q >= WAIT_LIMIT) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    rsp_rdata_d   = 8'hFF;
                    rsp_timeout_d = 1'b1;
                end else begin
                    wait_d = wait_q + CNT_W'(1);
                end
            end
            ST_HOLD: begin
                if (cnt_q == HOLD_LAST) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase

        req_ready_d  = (state_d == ST_IDLE);
        rsp_valid_d  = (state_q == ST_HOLD) && (state_d == ST_IDLE);
        bus_aen_d    = (state_d == ST_IDLE);
        bus_d_oe_d   = (state_d != ST_IDLE) && type_d[0];
        bus_ior_l_d  = !((state_d == ST_CMD) && (type_d == T_IOR));
        bus_iow_l_d  = !((state_d == ST_CMD) && (type_d == T_IOW));
        bus_memr_l_d = !((state_d == ST_CMD) && (type_d == T_MEMR));
        bus_memw_l_d = !((state_d == ST_CMD) && (type_d == T_MEMW));
    end

    // State and registered outputs; reset drops the bus to idle immediately
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            wait_q      <= '0;
            type_q      <= T_IOR;
            req_ready   <= 1'b1;
            rsp_valid   <= 1'b0;
            rsp_rdata   <= 8'hFF;
            rsp_timeout <= 1'b0;
            bus_a       <= '0;
            bus_aen     <= 1'b1;
            bus_ior_l   <= 1'b1;
            bus_iow_l   <= 1'b1;
            bus_memr_l  <= 1'b1;
            bus_memw_l  <= 1'b1;
            bus_d_out   <= '0;
            bus_d_oe    <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            wait_q      <= wait_d;
            type_q      <= type_d;
            req_ready   <= req_ready_d;
            rsp_valid   <= rsp_valid_d;
            rsp_rdata   <= rsp_rdata_d;
            rsp_timeout <= rsp_timeout_d;
            bus_a       <= bus_a_d;
            bus_aen     <= bus_aen_d;
            bus_ior_l   <= bus_ior_l_d;
            bus_iow_l   <= bus_iow_l_d;
            bus_memr_l  <= bus_memr_l_d;
            bus_memw_l  <= bus_memw_l_d;
            bus_d_out   <= bus_d_out_d;
            bus_d_oe    <= bus_d_oe_d;
        end
    end

endmodule

// File: tb/tb_isa_cycle_master.sv
// Directed bench for isa_cycle_master: IOW/IOR/MEMW/MEMR cycles, wait states, timeout,
// back-to-back requests and reset in the middle of a cycle.
module tb_isa_cycle_master;

`ifdef ISA_RDY_SYNC_EN
    localparam int LAG = 2;
`else
    localparam int LAG = 0;
`endif

    logic        clk = 1'b0;
    logic        reset_l;
    logic        req_valid, req_ready;
    logic [1:0]  req_type;
    logic [19:0] req_addr;
    logic [7:0]  req_wdata;
    logic        rsp_valid, rsp_timeout;
    logic [7:0]  rsp_rdata;
    logic [19:0] bus_a;
    logic        bus_aen, bus_ior_l, bus_iow_l, bus_memr_l, bus_memw_l;
    logic [7:0]  bus_d_out, bus_d_in;
    logic        bus_d_oe, bus_rdy;

    isa_cycle_master dut (
        .clk(clk), .reset_l(reset_l),
        .req_valid(req_valid), .req_ready(req_ready), .req_type(req_type),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_timeout(rsp_timeout),
        .bus_a(bus_a), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l),
        .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe),
        .bus_d_in(bus_d_in), .bus_rdy(bus_rdy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Observations of the most recent cycle, clock 0 = accept clock
    int          n_lo [4];
    int          multi, first_low, last_low, rsp_idx, wait_acc;
    logic [19:0] a_cmd;
    logic [7:0]  dout_cmd, rd_got;
    logic        oe_cmd, aen_cmd, tmo_got, aen_rsp, oe_rsp, rdy_rsp;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_req(input logic [1:0] t, input logic [19:0] a, input logic [7:0] wd,
                           input int rdy_low, input bit hold_valid);
        int  idx;
        int  nlow;
        bit  done;
        req_type  = t;
        req_addr  = a;
        req_wdata = wd;
        req_valid = 1'b1;
        bus_rdy   = (rdy_low == 0);
        wait_acc  = 0;
        while (!req_ready && wait_acc < 50) begin
            @(posedge clk); #1;
            wait_acc++;
        end
        @(posedge clk); #1;
        if (!hold_valid) req_valid = 1'b0;
        for (int k = 0; k < 4; k++) n_lo[k] = 0;
        multi = 0; first_low = -1; last_low = -1; rsp_idx = -1;
        idx = 1; done = 1'b0;
        while (!done && idx < 400) begin
            nlow = int'(!bus_ior_l) + int'(!bus_iow_l) + int'(!bus_memr_l) + int'(!bus_memw_l);
            if (nlow > 1) multi++;
            if (!bus_ior_l)  n_lo[0]++;
            if (!bus_iow_l)  n_lo[1]++;
            if (!bus_memr_l) n_lo[2]++;
            if (!bus_memw_l) n_lo[3]++;
            if (nlow != 0) begin
                if (first_low < 0) first_low = idx;
                last_low = idx;
                a_cmd = bus_a; oe_cmd = bus_d_oe; aen_cmd = bus_aen; dout_cmd = bus_d_out;
            end
            // target releases ready once the strobe has been low for rdy_low clocks
            if (n_lo[0] + n_lo[1] + n_lo[2] + n_lo[3] >= rdy_low) bus_rdy = 1'b1;
            if (rsp_valid) begin
                rsp_idx = idx; rd_got = rsp_rdata; tmo_got = rsp_timeout;
                aen_rsp = bus_aen; oe_rsp = bus_d_oe; rdy_rsp = req_ready;
                done = 1'b1;
            end else begin
                @(posedge clk); #1;
                idx++;
            end
        end
        req_valid = 1'b0;
        bus_rdy   = 1'b1;
    endtask

    task automatic check_cycle(input string nm, input int which, input int exp_lo,
                               input logic [19:0] exp_a, input bit exp_oe, input logic [7:0] exp_dout,
                               input int exp_idx, input logic [7:0] exp_rd, input bit exp_tmo);
        check({nm, "_ior_lo"},  n_lo[0], (which == 0) ? exp_lo : 0);
        check({nm, "_iow_lo"},  n_lo[1], (which == 1) ? exp_lo : 0);
        check({nm, "_memr_lo"}, n_lo[2], (which == 2) ? exp_lo : 0);
        check({nm, "_memw_lo"}, n_lo[3], (which == 3) ? exp_lo : 0);
        check({nm, "_multi"},   multi, 0);
        check({nm, "_addr"},    a_cmd, exp_a);
        check({nm, "_aen_cmd"}, aen_cmd, 0);
        check({nm, "_oe_cmd"},  oe_cmd, exp_oe);
        if (exp_oe) check({nm, "_dout"}, dout_cmd, exp_dout);
        check({nm, "_rsp_clk"}, rsp_idx, exp_idx);
        check({nm, "_rdata"},   rd_got, exp_rd);
        check({nm, "_timeout"}, tmo_got, exp_tmo);
        check({nm, "_aen_idle"}, aen_rsp, 1);
        check({nm, "_oe_idle"}, oe_rsp, 0);
        check({nm, "_ready_rsp"}, rdy_rsp, 1);
    endtask

    initial begin
        int l1, r1, pulses, g;
        reset_l = 1'b0; req_valid = 1'b0; req_type = 2'b00; req_addr = '0;
        req_wdata = '0; bus_d_in = 8'h00; bus_rdy = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ior",  bus_ior_l, 1);
        check("rst_iow",  bus_iow_l, 1);
        check("rst_memr", bus_memr_l, 1);
        check("rst_memw", bus_memw_l, 1);
        check("rst_aen",  bus_aen, 1);
        check("rst_a",    bus_a, 0);
        check("rst_dout", bus_d_out, 0);
        check("rst_oe",   bus_d_oe, 0);
        check("rst_ready", req_ready, 1);
        check("rst_rspv", rsp_valid, 0);
        check("rst_rdata", rsp_rdata, 8'hFF);
        check("rst_tmo",  rsp_timeout, 0);
        reset_l = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // IOW to the CGA mode register
        run_req(2'b01, 20'h003D8, 8'h29, 0, 1'b0);
        check_cycle("iow", 1, 4, 20'h003D8, 1'b1, 8'h29, 7, 8'hFF, 1'b0);

        // IOR of CGA status; upper address bits must be forced to zero
        bus_d_in = 8'hF9;
        run_req(2'b00, 20'hF03DA, 8'h00, 0, 1'b0);
        check_cycle("ior", 0, 4, 20'h003DA, 1'b0, 8'h00, 7, 8'hF9, 1'b0);

        // MEMW into CGA RAM with ready low for 10 strobe clocks
        run_req(2'b11, 20'hB8000, 8'h41, 10, 1'b0);
        check_cycle("memw_wait", 3, 10 + LAG, 20'hB8000, 1'b1, 8'h41, 13 + LAG, 8'hFF, 1'b0);

        // MEMR with ready stuck low: aborted by the timeout
        bus_d_in = 8'h5A;
        run_req(2'b10, 20'hB8002, 8'h00, 100000, 1'b0);
        check_cycle("memr_tmo", 2, 4 + 255, 20'hB8002, 1'b0, 8'h00, 262, 8'hFF, 1'b1);

        // Back-to-back with req_valid held: second accept in the rsp clock
        bus_d_in = 8'h3C;
        run_req(2'b01, 20'h003D9, 8'h0A, 0, 1'b1);
        check_cycle("b2b_iow", 1, 4, 20'h003D9, 1'b1, 8'h0A, 7, 8'hFF, 1'b0);
        l1 = last_low; r1 = rsp_idx;
        run_req(2'b00, 20'h003DA, 8'h00, 0, 1'b0);
        check("b2b_accept_wait", wait_acc, 0);
        check_cycle("b2b_ior", 0, 4, 20'h003DA, 1'b0, 8'h00, 7, 8'h3C, 1'b0);
        g = (r1 - l1 - 1) + first_low;
        check("b2b_strobe_gap", g, 3);

        // Reset during the command phase of a MEMW
        req_type = 2'b11; req_addr = 20'hB8010; req_wdata = 8'h55; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        g = 0;
        while (bus_memw_l && g < 20) begin
            @(posedge clk); #1;
            g++;
        end
        check("rstmid_reached_cmd", bus_memw_l, 0);
        #2 reset_l = 1'b0;
        #1;
        check("rstmid_memw", bus_memw_l, 1);
        check("rstmid_aen",  bus_aen, 1);
        check("rstmid_oe",   bus_d_oe, 0);
        check("rstmid_ready", req_ready, 1);
        check("rstmid_a",    bus_a, 0);
        @(posedge clk); #1;
        reset_l = 1'b1;
        pulses = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (rsp_valid) pulses++;
        end
        check("rstmid_no_rsp", pulses, 0);

        bus_d_in = 8'h77;
        run_req(2'b10, 20'hB8001, 8'h00, 0, 1'b0);
        check_cycle("after_rst", 2, 4, 20'hB8001, 1'b0, 8'h00, 7, 8'h77, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
